bnn_cmd_controller: RTL and testbench

Parametrised command/sequencing controller between the SPI byte receiver and the image buffer/BNN core, the next generation of the OCR command FSM. It decodes command bytes, streams exactly `IMG_BYTES` image bytes into the buffer, tracks its own write count, and starts the BNN with an explicit pulse. It latches the BNN class result, returns it over SPI on request, and optionally aborts a stalled image transfer by timeout.

---
 rtl/bnn_ctrl_pkg.sv | 26 ++
 rtl/bnn_ctrl_watchdog.sv | 32 +++
 rtl/bnn_cmd_controller.sv | 171 +++++++++++++++++
 tb/tb_bnn_cmd_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN command controller.
// Holds the FSM state encoding, host-visible status codes and the
// default SPI command bytes used by bnn_cmd_controller.
package bnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IMG,
    RX,
    BNN,
    RESULT,
    CLEAR
  } ctrl_state_t;

  localparam logic [3:0] ST_IDLE   = 4'h0;
  localparam logic [3:0] ST_WAIT   = 4'h1;
  localparam logic [3:0] ST_RX     = 4'h2;
  localparam logic [3:0] ST_BNN    = 4'h4;
  localparam logic [3:0] ST_RESULT = 4'h8;
  localparam logic [3:0] ST_ERROR  = 4'hE;

  localparam logic [7:0] DEF_CMD_IMG   = 8'hFE;
  localparam logic [7:0] DEF_CMD_CLEAR = 8'hFD;
  localparam logic [7:0] DEF_CMD_READ  = 8'hFC;

endpackage

// File: rtl/bnn_ctrl_watchdog.sv
// Inactivity watchdog for image transfers.
// Down-counter that reloads while inactive or on restart and flags
// expiry once LOAD_VALUE consecutive active cycles pass without restart.
module bnn_ctrl_watchdog #(
  parameter int unsigned LOAD_VALUE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CNT_W = (LOAD_VALUE > 1) ? $clog2(LOAD_VALUE + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOAD_VALUE - 1);

  logic [CNT_W-1:0] count;

  // Reload while idle or on every accepted byte, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RELOAD;
    end else if (!enable || restart) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = enable && !restart && (count == '0);

endmodule

// File: rtl/bnn_cmd_controller.sv
// Command/sequencing controller between the SPI byte receiver and the
// image buffer / BNN core. Decodes commands, streams IMG_BYTES image
// bytes into the buffer, starts inference and returns the class result.
// Optional feature: define BNN_CTRL_TIMEOUT_EN to abort stalled image
// transfers after TIMEOUT_CYCLES cycles without an accepted byte.
module bnn_cmd_controller
  import bnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned IMG_BYTES      = 113,
  parameter int unsigned ADDR_W         = $clog2(IMG_BYTES),
  parameter int unsigned RESULT_W       = 4,
  parameter logic [DATA_W-1:0] CMD_IMG   = DATA_W'(DEF_CMD_IMG),
  parameter logic [DATA_W-1:0] CMD_CLEAR = DATA_W'(DEF_CMD_CLEAR),
  parameter logic [DATA_W-1:0] CMD_READ  = DATA_W'(DEF_CMD_READ),
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_load,
  output logic [3:0]          status_code,
  output logic                buf_wr_en,
  output logic [ADDR_W-1:0]   buf_wr_addr,
  output logic [DATA_W-1:0]   buf_wr_data,
  output logic                buf_clear,
  input  logic                buf_empty,
  output logic                bnn_start,
  input  logic                result_valid,
  input  logic [RESULT_W-1:0] result_class
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  ctrl_state_t         state;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [RESULT_W-1:0] result_q;
  logic                started;
  logic                accept;
  logic                timeout_hit;
  logic                cmd_clear_req;
  logic                clear_req;

  assign accept = rx_valid && rx_ready;

`ifdef BNN_CTRL_TIMEOUT_EN
  logic wd_enable;
  assign wd_enable = (state == WAIT_IMG) || (state == RX);

  bnn_ctrl_watchdog #(
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (wd_enable),
    .restart (accept),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // CLEAR command is honoured everywhere except RX, where every byte is data;
  // a watchdog expiry only matters while an image transfer is in progress
  always_comb begin
    cmd_clear_req = 1'b0;
    clear_req     = 1'b0;
    if (accept && (rx_data == CMD_CLEAR) && (state != RX)) begin
      cmd_clear_req = 1'b1;
    end
    if (cmd_clear_req || (timeout_hit && ((state == WAIT_IMG) || (state == RX)))) begin
      clear_req = 1'b1;
    end
  end

  // Main sequencing FSM with all host/buffer/BNN outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      status_code <= ST_IDLE;
      rx_ready    <= 1'b1;
      tx_data     <= '0;
      tx_load     <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      buf_clear   <= 1'b0;
      bnn_start   <= 1'b0;
      wr_cnt      <= '0;
      result_q    <= '0;
      started     <= 1'b0;
    end else begin
      tx_load   <= 1'b0;
      buf_wr_en <= 1'b0;
      bnn_start <= 1'b0;
      if (clear_req) begin
        state       <= CLEAR;
        status_code <= cmd_clear_req ? ST_IDLE : ST_ERROR;
        rx_ready    <= 1'b0;
        buf_clear   <= 1'b1;
        wr_cnt      <= '0;
        result_q    <= '0;
        started     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (rx_data == CMD_IMG) begin
                state       <= WAIT_IMG;
                status_code <= ST_WAIT;
                wr_cnt      <= '0;
                started     <= 1'b0;
              end else begin
                status_code <= ST_ERROR;
              end
            end
          end
          WAIT_IMG, RX: begin
            if (accept) begin
              buf_wr_en   <= 1'b1;
              buf_wr_addr <= wr_cnt;
              buf_wr_data <= rx_data;
              if (wr_cnt == LAST_ADDR) begin
                state       <= BNN;
                status_code <= ST_BNN;
              end else begin
                wr_cnt      <= wr_cnt + ADDR_W'(1);
                state       <= RX;
                status_code <= ST_RX;
              end
            end
          end
          BNN: begin
            if (!started) begin
              bnn_start <= 1'b1;
              started   <= 1'b1;
            end else if (result_valid) begin
              result_q    <= result_class;
              state       <= RESULT;
              status_code <= ST_RESULT;
            end
          end
          RESULT: begin
            if (accept && (rx_data == CMD_READ)) begin
              tx_data <= DATA_W'(result_q);
              tx_load <= 1'b1;
            end
          end
          CLEAR: begin
            status_code <= ST_IDLE;
            if (buf_empty) begin
              state     <= IDLE;
              buf_clear <= 1'b0;
              rx_ready  <= 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            status_code <= ST_IDLE;
            rx_ready    <= 1'b1;
            buf_clear   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bnn_cmd_controller.sv
// Directed self-checking bench for bnn_cmd_controller.
// Builds with the watchdog when BNN_CTRL_TIMEOUT_EN is defined, using a
// 50-cycle timeout so the stall scenario stays short.
module tb_bnn_cmd_controller;

`ifdef BNN_CTRL_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 50;
`else
  localparam int unsigned TB_TIMEOUT = 1_000_000;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [3:0] status_code;
  logic       buf_wr_en;
  logic [6:0] buf_wr_addr;
  logic [7:0] buf_wr_data;
  logic       buf_clear;
  logic       buf_empty;
  logic       bnn_start;
  logic       result_valid;
  logic [3:0] result_class;

  int tests_run;
  int tests_failed;
  int wr_seen;
  int start_seen;
  int load_seen;
  int clear_seen;
  logic [7:0] mem [0:127];

  bnn_cmd_controller #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .status_code  (status_code),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .buf_wr_data  (buf_wr_data),
    .buf_clear    (buf_clear),
    .buf_empty    (buf_empty),
    .bnn_start    (bnn_start),
    .result_valid (result_valid),
    .result_class (result_class)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe buffer writes and pulse outputs mid-cycle
  always @(negedge clk) begin
    if (buf_wr_en) begin
      mem[buf_wr_addr] = buf_wr_data;
      wr_seen = wr_seen + 1;
    end
    if (bnn_start) start_seen = start_seen + 1;
    if (tx_load)   load_seen  = load_seen + 1;
    if (buf_clear) clear_seen = clear_seen + 1;
  end

  // Present one byte and hold it until the controller accepts it
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    rx_data  = b;
    rx_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_byte_accept: byte %h not accepted within 100 cycles", b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tests_run++;
    if (status_code !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_status: got %h expected 0", status_code); end
    tests_run++;
    if (rx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    tests_run++;
    if ({tx_load, buf_wr_en, buf_clear, bnn_start} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {tx_load, buf_wr_en, buf_clear, bnn_start});
    end
    tests_run++;
    if ({tx_data, buf_wr_addr, buf_wr_data} !== 23'd0) begin
      tests_failed++; $display("[TB] FAIL reset_data: tx %h addr %h wdata %h expected all 0", tx_data, buf_wr_addr, buf_wr_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_normal_image();
    wr_seen = 0;
    start_seen = 0;
    send_byte(8'hFE);
    tests_run++;
    if (status_code !== 4'h1) begin tests_failed++; $display("[TB] FAIL img_status_wait: got %h expected 1", status_code); end
    send_byte(8'h00);
    tests_run++;
    if (status_code !== 4'h2) begin tests_failed++; $display("[TB] FAIL img_status_rx: got %h expected 2", status_code); end
    tests_run++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data} !== {1'b1, 7'd0, 8'h00}) begin
      tests_failed++; $display("[TB] FAIL img_first_write: en %b addr %0d data %h expected en 1 addr 0 data 00", buf_wr_en, buf_wr_addr, buf_wr_data);
    end
    for (int i = 1; i < 113; i++) send_byte(8'(i));
    tests_run++;
    if (status_code !== 4'h4) begin tests_failed++; $display("[TB] FAIL img_status_bnn: got %h expected 4", status_code); end
    tests_run++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data, bnn_start} !== {1'b1, 7'd112, 8'h70, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL img_last_write: en %b addr %0d data %h start %b expected 1 112 70 0", buf_wr_en, buf_wr_addr, buf_wr_data, bnn_start);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({bnn_start, buf_wr_en} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL img_start_pulse: start %b wr_en %b expected start 1 wr_en 0", bnn_start, buf_wr_en);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (wr_seen !== 113) begin tests_failed++; $display("[TB] FAIL img_write_count: got %0d expected 113", wr_seen); end
    tests_run++;
    if (start_seen !== 1) begin tests_failed++; $display("[TB] FAIL img_start_count: got %0d expected 1", start_seen); end
    for (int i = 0; i < 113; i++) begin
      tests_run++;
      if (mem[i] !== 8'(i)) begin tests_failed++; $display("[TB] FAIL img_data[%0d]: got %h expected %h", i, mem[i], 8'(i)); end
    end
  endtask

  task automatic test_readback();
    load_seen = 0;
    result_class = 4'd7;
    result_valid = 1'b1;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    tests_run++;
    if (status_code !== 4'h8) begin tests_failed++; $display("[TB] FAIL rd_status_result: got %h expected 8", status_code); end
    for (int k = 0; k < 2; k++) begin
      send_byte(8'hFC);
      tests_run++;
      if ({tx_load, tx_data} !== {1'b1, 8'h07}) begin
        tests_failed++; $display("[TB] FAIL rd_load_%0d: load %b data %h expected load 1 data 07", k, tx_load, tx_data);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (tx_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_load_single_%0d: got %b expected 0", k, tx_load); end
    end
    tests_run++;
    if (load_seen !== 2) begin tests_failed++; $display("[TB] FAIL rd_load_count: got %0d expected 2", load_seen); end
    send_byte(8'hFD);
    tests_run++;
    if ({status_code, buf_clear, rx_ready} !== {4'h0, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL rd_clear_enter: status %h clear %b ready %b expected 0 1 0", status_code, buf_clear, rx_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({status_code, buf_clear, rx_ready} !== {4'h0, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL rd_clear_exit: status %h clear %b ready %b expected 0 0 1", status_code, buf_clear, rx_ready);
    end
  endtask

  task automatic test_cmd_as_data();
    logic [7:0] b;
    wr_seen = 0;
    clear_seen = 0;
    send_byte(8'hFE);
    for (int i = 0; i < 113; i++) begin
      b = (i == 5) ? 8'hFD : (i == 6) ? 8'hFC : 8'(i);
      send_byte(b);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({mem[5], mem[6]} !== 16'hFDFC) begin tests_failed++; $display("[TB] FAIL cmd_data_bytes: got %h %h expected FD FC", mem[5], mem[6]); end
    tests_run++;
    if (wr_seen !== 113) begin tests_failed++; $display("[TB] FAIL cmd_data_count: got %0d expected 113", wr_seen); end
    tests_run++;
    if (clear_seen !== 0) begin tests_failed++; $display("[TB] FAIL cmd_data_no_clear: got %0d clear cycles expected 0", clear_seen); end
    tests_run++;
    if (status_code !== 4'h4) begin tests_failed++; $display("[TB] FAIL cmd_data_status: got %h expected 4", status_code); end
  endtask

  task automatic test_collision();
    rx_data = 8'hFD;
    rx_valid = 1'b1;
    result_valid = 1'b1;
    result_class = 4'd7;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    result_valid = 1'b0;
    tests_run++;
    if ({status_code, buf_clear} !== {4'h0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL coll_clear_wins: status %h clear %b expected 0 1", status_code, buf_clear);
    end
    @(posedge clk);
    #1;
    load_seen = 0;
    send_byte(8'hFE);
    send_byte(8'hFC);
    tests_run++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data} !== {1'b1, 7'd0, 8'hFC}) begin
      tests_failed++; $display("[TB] FAIL coll_fc_as_data: en %b addr %0d data %h expected 1 0 FC", buf_wr_en, buf_wr_addr, buf_wr_data);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (load_seen !== 0) begin tests_failed++; $display("[TB] FAIL coll_no_readback: got %0d loads expected 0", load_seen); end
  endtask

  task automatic test_mid_reset();
    send_byte(8'h55);
    @(posedge clk);
    #1;
    wr_seen = 0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (wr_seen !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_write: got %0d writes expected 0", wr_seen); end
    tests_run++;
    if ({status_code, buf_clear} !== {4'h0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL midrst_idle: status %h clear %b expected 0 0", status_code, buf_clear);
    end
    send_byte(8'hFE);
    send_byte(8'h9A);
    tests_run++;
    if ({buf_wr_en, buf_wr_addr} !== {1'b1, 7'd0}) begin
      tests_failed++; $display("[TB] FAIL midrst_restart_addr: en %b addr %0d expected 1 0", buf_wr_en, buf_wr_addr);
    end
    do_reset();
  endtask

  task automatic test_bad_command();
    send_byte(8'h12);
    tests_run++;
    if ({status_code, buf_wr_en} !== {4'hE, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bad_cmd_status: status %h wr_en %b expected E 0", status_code, buf_wr_en);
    end
    send_byte(8'h34);
    tests_run++;
    if (status_code !== 4'hE) begin tests_failed++; $display("[TB] FAIL bad_cmd_sticky: got %h expected E", status_code); end
    buf_empty = 1'b0;
    send_byte(8'hFD);
    tests_run++;
    if ({status_code, buf_clear, rx_ready} !== {4'h0, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bad_clear_enter: status %h clear %b ready %b expected 0 1 0", status_code, buf_clear, rx_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({buf_clear, rx_ready} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL bad_clear_hold: clear %b ready %b expected 1 0", buf_clear, rx_ready);
    end
    buf_empty = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({status_code, buf_clear, rx_ready} !== {4'h0, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL bad_clear_exit: status %h clear %b ready %b expected 0 0 1", status_code, buf_clear, rx_ready);
    end
  endtask

`ifdef BNN_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    logic seen;
    do_reset();
    send_byte(8'hFE);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h20));
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 80) begin
      @(posedge clk);
      #1;
      waited++;
      if (status_code === 4'hE) seen = 1'b1;
    end
    tests_run++;
    if (!seen || waited != 50) begin
      tests_failed++; $display("[TB] FAIL timeout_fire: seen %b after %0d cycles expected 1 after 50", seen, waited);
    end
    tests_run++;
    if (buf_clear !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_clear: got %b expected 1", buf_clear); end
    @(posedge clk);
    #1;
    tests_run++;
    if ({status_code, buf_clear} !== {4'h0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL timeout_idle: status %h clear %b expected 0 0", status_code, buf_clear);
    end
    wr_seen = 0;
    send_byte(8'hFE);
    send_byte(8'hA5);
    tests_run++;
    if ({buf_wr_en, buf_wr_addr} !== {1'b1, 7'd0}) begin
      tests_failed++; $display("[TB] FAIL timeout_restart_addr: en %b addr %0d expected 1 0", buf_wr_en, buf_wr_addr);
    end
    for (int i = 1; i < 113; i++) send_byte(8'(i));
    @(posedge clk);
    #1;
    tests_run++;
    if (wr_seen !== 113) begin tests_failed++; $display("[TB] FAIL timeout_full_image: got %0d writes expected 113", wr_seen); end
  endtask
`endif

  // Scenario sequence
  initial begin
    tests_run = 0;
    tests_failed = 0;
    wr_seen = 0;
    start_seen = 0;
    load_seen = 0;
    clear_seen = 0;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    buf_empty = 1'b1;
    result_valid = 1'b0;
    result_class = 4'd0;
    test_reset();
    test_normal_image();
    test_readback();
    test_cmd_as_data();
    test_collision();
    test_mid_reset();
    test_bad_command();
`ifdef BNN_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
